// File: rtl/sensor_pkg.sv
// sensor_pkg: shared state encoding, timing constants and helpers for the
// sensor frame controller and its ADC ramp.
package sensor_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_ROW_SEL,
    S_ROW_CAP,
    S_STREAM
  } state_t;
  localparam int ROW_SETTLE = 1;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pix_code_t;
  // bits needed to hold 0..max_val, never less than one
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/adc_ramp_counter.sv
// adc_ramp_counter: ramp code generator for the comparator-based ADC;
// counts up while enabled and flags the maximum code.
module adc_ramp_counter
  import sensor_pkg::*;
#(
  parameter int W = $bits(pix_code_t)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_code,
  output logic         o_done
);
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) o_code <= '0;
    else if (i_en) o_code <= o_code + 1'b1;
  end
  assign o_done = &o_code;
endmodule

// File: rtl/sensor_frame_ctrl.sv
// sensor_frame_ctrl: sequences erase, exposure, ramp conversion and row readout
// of a ROWS x COLS pixel array, streaming pixels over valid/ready.
module sensor_frame_ctrl
  import sensor_pkg::*;
#(
  parameter int ROWS         = 2,
  parameter int COLS         = 2,
  parameter int ADC_W        = $bits(pix_code_t),
  parameter int EXP_W        = 8,
  parameter int ERASE_CYCLES = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic                  i_stop,
  input  logic [EXP_W-1:0]      i_exp_time,
  output logic                  o_erase,
  output logic                  o_expose,
  output logic                  o_convert,
  output logic [ADC_W-1:0]      o_adc_code,
  output logic [ROWS-1:0]       o_row_sel,
  input  logic [COLS*ADC_W-1:0] i_pix_data,
  output logic [ADC_W-1:0]      o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last,
  output logic                  o_busy
);
  localparam int ER_W  = cnt_w(ERASE_CYCLES - 1);
  localparam int ROW_W = cnt_w(ROWS - 1);
  localparam int COL_W = cnt_w(COLS - 1);
  localparam int ST_W  = cnt_w(ROW_SETTLE - 1);
  localparam logic [ER_W-1:0]  ER_LAST  = ER_W'(ERASE_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(ROW_SETTLE - 1);
  state_t                r_state;
  logic                  r_cont;
  logic [EXP_W-1:0]      r_exp;
  logic [EXP_W-1:0]      r_exp_cnt;
  logic [ER_W-1:0]       r_er_cnt;
  logic [ST_W-1:0]       r_settle;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [COLS*ADC_W-1:0] r_buf;
  logic                  w_ramp_en;
  logic                  w_ramp_clr;
  logic                  w_ramp_done;
  logic                  w_last_row;
  logic                  w_last_col;
  logic                  w_cont_next;
  logic [EXP_W-1:0]      w_exp_eff;
  assign w_exp_eff   = (i_exp_time == '0) ? EXP_W'(1) : i_exp_time;
  assign w_last_row  = r_row == ROW_LAST;
  assign w_last_col  = r_col == COL_LAST;
  assign w_cont_next = r_cont & ~i_stop;
  // the ramp clears itself on its max-code cycle so it idles at zero
  assign w_ramp_en   = (r_state == S_CONVERT) & ~w_ramp_done;
  assign w_ramp_clr  = (r_state == S_CONVERT) & w_ramp_done;
  assign o_out_data  = o_out_valid ? r_buf[r_col*ADC_W +: ADC_W] : '0;
  adc_ramp_counter #(.W(ADC_W)) u_ramp (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_ramp_en),
    .i_clr   (w_ramp_clr),
    .o_code  (o_adc_code),
    .o_done  (w_ramp_done)
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cont      <= 1'b0;
      r_exp       <= '0;
      r_exp_cnt   <= '0;
      r_er_cnt    <= '0;
      r_settle    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_buf       <= '0;
      o_erase     <= 1'b0;
      o_expose    <= 1'b0;
      o_convert   <= 1'b0;
      o_row_sel   <= '0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      if (i_stop) r_cont <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state  <= S_ERASE;
          r_cont   <= i_continuous & ~i_stop;
          r_exp    <= w_exp_eff;
          r_er_cnt <= '0;
          o_erase  <= 1'b1;
          o_busy   <= 1'b1;
        end
        S_ERASE: if (r_er_cnt == ER_LAST) begin
          r_er_cnt  <= '0;
          r_exp_cnt <= '0;
          r_state   <= S_EXPOSE;
          o_erase   <= 1'b0;
          o_expose  <= 1'b1;
        end else r_er_cnt <= r_er_cnt + 1'b1;
        S_EXPOSE: if (r_exp_cnt == r_exp - 1'b1) begin
          r_exp_cnt <= '0;
          r_state   <= S_CONVERT;
          o_expose  <= 1'b0;
          o_convert <= 1'b1;
        end else r_exp_cnt <= r_exp_cnt + 1'b1;
        S_CONVERT: if (w_ramp_done) begin
          r_state   <= S_ROW_SEL;
          r_row     <= '0;
          r_settle  <= '0;
          o_convert <= 1'b0;
          o_row_sel <= ROWS'(1);
        end
        S_ROW_SEL: if (r_settle == ST_LAST) begin
          r_settle <= '0;
          r_state  <= S_ROW_CAP;
        end else r_settle <= r_settle + 1'b1;
        S_ROW_CAP: begin
          r_buf       <= i_pix_data;
          r_col       <= '0;
          r_state     <= S_STREAM;
          o_out_valid <= 1'b1;
          o_out_last  <= w_last_row && (COLS == 1);
        end
        S_STREAM: if (i_out_ready) begin
          if (!w_last_col) begin
            r_col      <= r_col + 1'b1;
            o_out_last <= w_last_row && (r_col + 1'b1 == COL_LAST);
          end else begin
            r_col       <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            if (!w_last_row) begin
              r_row     <= r_row + 1'b1;
              o_row_sel <= o_row_sel << 1;
              r_state   <= S_ROW_SEL;
            end else begin
              r_row     <= '0;
              o_row_sel <= '0;
              // a stop arriving on the final handshake still ends the run
              if (w_cont_next) begin
                r_state <= S_ERASE;
                r_exp   <= w_exp_eff;
                o_erase <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
